// File: rtl/regfile_pkg.sv
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared constants and state encoding for the 32x32 register
//                file, its write-port controller and the writeback mux.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int DW   = 32;       // data width
    localparam int AW   = 5;        // register address width
    localparam int NREG = 2 ** AW;  // number of registers

    // Write-port controller states
    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

endpackage : regfile_pkg

`default_nettype wire

// File: rtl/rw_arb2.sv
// ============================================================================
//  Module      : rw_arb2
//  Description : Two-request write-port arbiter. gnt is one-hot or zero.
//                req[0]/gnt[0] = requester A, req[1]/gnt[1] = requester B.
//                Build option REGWR_ARB_RR_EN: round-robin on conflict
//                (pointer remembers last grantee, resets to B). Without it,
//                fixed priority with A winning every conflict.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rw_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

`ifdef REGWR_ARB_RR_EN
    // High when B was the most recent grantee; starts at B so A wins first
    logic r_last_b;

    // Track the last grantee on every grant, contested or not
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_b <= 1'b1;
        end else if (|gnt) begin
            r_last_b <= gnt[1];
        end
    end

    // On conflict grant whoever was not served last; otherwise pass request
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = r_last_b ? 2'b01 : 2'b10;
        end
    end
`else
    // Clock and reset have no state to drive in the fixed-priority build
    logic w_unused_clk_rst;
    assign w_unused_clk_rst = clk ^ rst;

    // Fixed priority: A always beats B
    always_comb begin
        gnt = 2'b00;
        if (req[0]) begin
            gnt = 2'b01;
        end else if (req[1]) begin
            gnt = 2'b10;
        end
    end
`endif

endmodule : rw_arb2

`default_nettype wire

// File: rtl/regfile_write_ctrl.sv
// ============================================================================
//  Module      : regfile_write_ctrl
//  Description : Owns the register file write port. After every reset it
//                writes zero to r0..r(NREG-1), then shares the port between
//                requesters A and B via valid/ready. Writes to r0 are
//                accepted but dropped. Outputs are registered.
//                Build option REGWR_ARB_RR_EN selects round-robin arbitration
//                (default: fixed priority, A first).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_write_ctrl
    import regfile_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          a_valid,
    input  logic [AW-1:0] a_rw,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [AW-1:0] b_rw,
    input  logic [DW-1:0] b_wdata,
    output logic          b_ready,
    output logic          RegWrite,
    output logic [AW-1:0] rw,
    output logic [DW-1:0] wdata,
    output logic          init_done
);

    localparam logic [AW-1:0] c_cnt_last = AW'(NREG - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_cnt;
    logic [AW-1:0] w_cnt_nxt;
    logic          r_regwrite;
    logic          w_regwrite_nxt;
    logic [AW-1:0] r_rw;
    logic [AW-1:0] w_rw_nxt;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] w_wdata_nxt;
    logic [1:0]    w_req;
    logic [1:0]    w_gnt;

    // Requesters are invisible until the clear sequence has finished
    assign w_req = (r_state == ST_RUN) ? {b_valid, a_valid} : 2'b00;

    rw_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req (w_req),
        .gnt (w_gnt)
    );

    assign a_ready   = w_gnt[0];
    assign b_ready   = w_gnt[1];
    assign RegWrite  = r_regwrite;
    assign rw        = r_rw;
    assign wdata     = r_wdata;
    assign init_done = (r_state == ST_RUN);

    // State, clear counter and the output register feeding the register file
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_CLEAR;
            r_cnt      <= '0;
            r_regwrite <= 1'b0;
            r_rw       <= '0;
            r_wdata    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_regwrite <= w_regwrite_nxt;
            r_rw       <= w_rw_nxt;
            r_wdata    <= w_wdata_nxt;
        end
    end

    // Next state: sweep zeros across the file, then forward granted writes
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_regwrite_nxt = 1'b0;
        w_rw_nxt       = r_rw;
        w_wdata_nxt    = r_wdata;
        case (r_state)
            ST_CLEAR: begin
                w_regwrite_nxt = 1'b1;
                w_rw_nxt       = r_cnt;
                w_wdata_nxt    = '0;
                w_cnt_nxt      = r_cnt + AW'(1);
                if (r_cnt == c_cnt_last) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // A write to r0 is still handshaken but never reaches the file
                if (w_gnt[0]) begin
                    w_regwrite_nxt = |a_rw;
                    w_rw_nxt       = a_rw;
                    w_wdata_nxt    = a_wdata;
                end else if (w_gnt[1]) begin
                    w_regwrite_nxt = |b_rw;
                    w_rw_nxt       = b_rw;
                    w_wdata_nxt    = b_wdata;
                end
            end
            default: begin
                w_state_nxt = ST_CLEAR;
            end
        endcase
    end

endmodule : regfile_write_ctrl

`default_nettype wire
